// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit.
//   cond_e     : 4-bit condition code encoding (EQ..NV)
//   FLAG_*     : bit positions of N/Z/C/V inside the 4-bit flag word
//   cond_pass(): pure condition evaluation against a flag word
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic cond_pass(input cond_e cond, input logic [3:0] flags);
      logic n, z, c, v;
      logic pass;
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      case (cond)
         EQ:      pass = z;
         NE:      pass = !z;
         CS:      pass = c;
         CC:      pass = !c;
         MI:      pass = n;
         PL:      pass = !n;
         VS:      pass = v;
         VC:      pass = !v;
         HI:      pass = c && !z;
         LS:      pass = !c || z;
         GE:      pass = (n == v);
         LT:      pass = (n != v);
         GT:      pass = !z && (n == v);
         LE:      pass = z || (n != v);
         AL:      pass = 1'b1;
         default: pass = 1'b0;   // NV
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator.
//   cond_i  : 4-bit condition code
//   flags_i : NZCV flag word ([3]=N, [2]=Z, [1]=C, [0]=V)
//   pass_o  : 1 when the condition holds for the given flags
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       pass_o
);

   assign pass_o = cond_pass(cond_e'(cond_i), flags_i);

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural NZCV register, condition evaluation with a
// registered execute/skip decision, and a flag-hazard interlock that stalls
// conditional instructions while flag writers are still in flight.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   cond_valid_i, cond_i    : issue request and its condition code
//   sets_flags_i            : issued instruction will later write flags
//   cond_ready_o            : issue accepted when high with cond_valid_i
//   status_i, set_status_i  : ALU flag value and write strobe
//   flush_i                 : pipeline flush
//   exec_valid_o, exec_o    : one-cycle decision pulse and pass result
//   flags_o, pending_o      : flag register and outstanding writer count
module cond_unit
   import cond_pkg::*;
#(
   parameter  int MAX_PENDING = 3,
   localparam int PCNT_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cond_valid_i,
   input  logic [3:0]        cond_i,
   input  logic              sets_flags_i,
   output logic              cond_ready_o,
   input  logic [3:0]        status_i,
   input  logic              set_status_i,
   input  logic              flush_i,
   output logic              exec_valid_o,
   output logic              exec_o,
   output logic [3:0]        flags_o,
   output logic [PCNT_W-1:0] pending_o
);

   localparam logic [PCNT_W-1:0] PEND_FULL = PCNT_W'(MAX_PENDING);

   logic [3:0]        flags_q;
   logic [PCNT_W-1:0] pending_q;
   logic [PCNT_W-1:0] pending_eff;
   logic [PCNT_W-1:0] pending_d;
   logic [3:0]        flags_eff;
   logic              dec;
   logic              inc;
   logic              hazard;
   logic              full;
   logic              hs_p0;
   logic              pass_p0;
   logic              vld_p1;
   logic              exec_p1;

   // Same-cycle forward lets a conditional issue alongside the flag write
   // that resolves its hazard.
   assign flags_eff = set_status_i ? status_i : flags_q;

   // A flag write with nothing outstanding only updates the flags.
   assign dec         = set_status_i && (pending_q != '0);
   assign pending_eff = pending_q - PCNT_W'(dec);

   assign hazard = (cond_i != AL) && (cond_i != NV) && (pending_eff != '0);
   assign full   = sets_flags_i && (pending_q == PEND_FULL) && !set_status_i;

   assign cond_ready_o = !(hazard || full);

   // Flush drops any issue in its cycle even though ready is still shown.
   assign hs_p0 = cond_valid_i && cond_ready_o && !flush_i;
   assign inc   = hs_p0 && sets_flags_i;

   assign pending_d = flush_i ? '0 : (pending_q + PCNT_W'(inc) - PCNT_W'(dec));

   cond_eval u_eval (
      .cond_i  (cond_i),
      .flags_i (flags_eff),
      .pass_o  (pass_p0)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         flags_q   <= '0;
         pending_q <= '0;
      end else begin
         if (set_status_i) begin
            flags_q <= status_i;
         end
         pending_q <= pending_d;
      end
   end

   // ---- stage p0 -> p1: registered execute decision ----
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         vld_p1  <= 1'b0;
         exec_p1 <= 1'b0;
      end else begin
         vld_p1  <= hs_p0;
         exec_p1 <= pass_p0;
      end
   end

   assign exec_valid_o = vld_p1;
   assign exec_o       = exec_p1;
   assign flags_o      = flags_q;
   assign pending_o    = pending_q;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

   localparam int MAXP = 3;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       cond_valid_i = 1'b0;
   logic [3:0] cond_i = 4'h0;
   logic       sets_flags_i = 1'b0;
   logic       cond_ready_o;
   logic [3:0] status_i = 4'h0;
   logic       set_status_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       exec_valid_o;
   logic       exec_o;
   logic [3:0] flags_o;
   logic [1:0] pending_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;

   cond_unit #(.MAX_PENDING(MAXP)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .cond_valid_i (cond_valid_i),
      .cond_i       (cond_i),
      .sets_flags_i (sets_flags_i),
      .cond_ready_o (cond_ready_o),
      .status_i     (status_i),
      .set_status_i (set_status_i),
      .flush_i      (flush_i),
      .exec_valid_o (exec_valid_o),
      .exec_o       (exec_o),
      .flags_o      (flags_o),
      .pending_o    (pending_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Conditions come in complementary pairs: the low bit of the code inverts
   // a base predicate selected by the upper three bits (pair 7 is AL/NV).
   function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      logic base [8];
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      base[0] = z;
      base[1] = cy;
      base[2] = n;
      base[3] = v;
      base[4] = cy & ~z;
      base[5] = (n == v);
      base[6] = ~z & (n == v);
      base[7] = 1'b1;
      return base[c[3:1]] ^ c[0];
   endfunction

   int         m_pending = 0;
   logic [3:0] m_flags = 4'h0;
   logic       m_vld = 1'b0;
   logic       m_exec = 1'b0;

   function automatic logic m_ready();
      int after_write;
      after_write = (set_status_i && m_pending > 0) ? m_pending - 1 : m_pending;
      if (cond_i != 4'hE && cond_i != 4'hF && after_write != 0) return 1'b0;
      if (sets_flags_i && m_pending == MAXP && !set_status_i) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk_i) begin
      logic hs;
      logic [3:0] eff;
      started <= 1'b1;
      if (!rst_n_i) begin
         m_pending <= 0;
         m_flags   <= 4'h0;
         m_vld     <= 1'b0;
         m_exec    <= 1'b0;
      end else begin
         hs  = cond_valid_i && m_ready() && !flush_i;
         eff = set_status_i ? status_i : m_flags;
         if (set_status_i) m_flags <= status_i;
         if (flush_i)
            m_pending <= 0;
         else
            m_pending <= m_pending + ((hs && sets_flags_i) ? 1 : 0)
                                   - ((set_status_i && m_pending > 0) ? 1 : 0);
         m_vld  <= hs;
         m_exec <= m_pass(cond_i, eff);
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk_i) begin
      if (started) begin
         chk("ready", cond_ready_o, m_ready());
         chk("exec_valid", exec_valid_o, m_vld);
         if (m_vld) chk("exec", exec_o, m_exec);
         chk("flags", flags_o, m_flags);
         chk("pending", pending_o, m_pending);
      end
   end

   // Drive one cycle of inputs just after the rising edge, return mid-cycle.
   task automatic cyc(input logic v, input logic [3:0] c, input logic sf,
                      input logic [3:0] st, input logic ss, input logic fl);
      @(posedge clk_i);
      #1;
      cond_valid_i = v;
      cond_i       = c;
      sets_flags_i = sf;
      status_i     = st;
      set_status_i = ss;
      flush_i      = fl;
      @(negedge clk_i);
   endtask

   task automatic idle();
      cyc(1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   logic [3:0] prev_c;

   initial begin
      // reset
      idle();
      idle();
      chk("rst_flags", flags_o, 32'h0);
      chk("rst_pending", pending_o, 32'h0);
      chk("rst_exec_valid", exec_valid_o, 32'h0);
      chk("rst_exec", exec_o, 32'h0);
      chk("rst_ready", cond_ready_o, 32'h1);
      rst_n_i = 1'b1;

      // basic EQ / NE on zero flags
      cyc(1, 4'h0, 0, 4'h0, 0, 0);
      cyc(1, 4'h1, 0, 4'h0, 0, 0);
      chk("eq_valid", exec_valid_o, 32'h1);
      chk("eq_exec", exec_o, 32'h0);
      idle();
      chk("ne_exec", exec_o, 32'h1);

      // forwarding
      cyc(1, 4'h0, 0, 4'h4, 1, 0);
      idle();
      chk("fwd_exec", exec_o, 32'h1);
      chk("fwd_flags", flags_o, 32'h4);

      // hazard
      cyc(1, 4'hE, 1, 4'h0, 0, 0);
      cyc(1, 4'hA, 0, 4'h0, 0, 0);
      chk("haz_pending", pending_o, 32'h1);
      chk("haz_ready0", cond_ready_o, 32'h0);
      cyc(1, 4'hA, 0, 4'h0, 0, 0);
      chk("haz_ready1", cond_ready_o, 32'h0);
      cyc(1, 4'hA, 0, 4'h0, 0, 0);
      chk("haz_ready2", cond_ready_o, 32'h0);
      cyc(1, 4'hA, 0, 4'h9, 1, 0);
      chk("haz_release", cond_ready_o, 32'h1);
      idle();
      chk("haz_exec", exec_o, 32'h1);
      chk("haz_pend0", pending_o, 32'h0);

      // full counter
      repeat (3) cyc(1, 4'hE, 1, 4'h0, 0, 0);
      cyc(1, 4'hE, 1, 4'h0, 0, 0);
      chk("full_pending", pending_o, 32'h3);
      chk("full_ready", cond_ready_o, 32'h0);
      cyc(1, 4'hE, 1, 4'h0, 1, 0);
      chk("full_ss_ready", cond_ready_o, 32'h1);
      idle();
      chk("full_ss_pending", pending_o, 32'h3);

      // flush
      cyc(0, 4'hE, 0, 4'h0, 1, 0);
      cyc(1, 4'hC, 0, 4'h0, 0, 1);
      chk("flush_pending_before", pending_o, 32'h2);
      cyc(1, 4'hC, 0, 4'h0, 0, 0);
      chk("flush_pending", pending_o, 32'h0);
      chk("flush_exec_valid", exec_valid_o, 32'h0);
      chk("flush_gt_ready", cond_ready_o, 32'h1);
      idle();
      chk("flush_gt_exec", exec_o, 32'h1);

      // exhaustive evaluation via the forward path
      prev_c = 4'h0;
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            cyc(1, 4'(c), 0, 4'(f), 1, 0);
            if (f != 0 || c != 0) begin
               if (prev_c == 4'hE) chk("al_always", exec_o, 32'h1);
               if (prev_c == 4'hF) chk("nv_never", exec_o, 32'h0);
            end
            prev_c = 4'(c);
         end
      end
      idle();
      chk("nv_last", exec_o, 32'h0);

      // reset in the middle of a stall
      cyc(1, 4'hE, 1, 4'h0, 0, 0);
      cyc(1, 4'hA, 0, 4'h0, 0, 0);
      chk("stall_before_rst", cond_ready_o, 32'h0);
      rst_n_i = 1'b0;
      idle();
      chk("rst_mid_pending", pending_o, 32'h0);
      chk("rst_mid_flags", flags_o, 32'h0);
      rst_n_i = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) rst_n_i = 1'b0;
         else rst_n_i = 1'b1;
         cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
      end
      rst_n_i = 1'b1;
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
